seven_seg_capture_decoder: RTL

- Decodes the display side of the BCD-to-7-segment path back to BCD. It watches a time-multiplexed 7-segment bus with a one-hot digit select and rebuilds the per-digit BCD values.
- A digit is committed only after its pattern is stable for STABLE consecutive samples, which filters scan glitches.
- Used as a self-check and readback monitor alongside the counter/display path.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_pattern_to_bcd.sv | 31 +++
 rtl/seven_seg_capture_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Segment pattern table shared by the BCD-to-7-segment encoder and
// the capture-side decoder, so both directions use identical codes.
package seg7_pkg;

  // seg[6]=a ... seg[0]=g, active-high
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational reverse lookup: 7-segment pattern to BCD digit.
// Blank decodes to BCD_BLANK; any other unlisted pattern is illegal.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  // Table lookup against the shared pattern constants
  always_comb begin
    bcd   = '0;
    legal = 1'b1;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture_decoder.sv
// Rebuilds per-digit BCD values from a time-multiplexed 7-segment bus.
// A digit commits only after STABLE consecutive identical legal samples
// on that digit; samples of other digits do not break the run.
module seven_seg_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     digit_sel,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic [NDIG-1:0]     digit_valid,
  output logic                upd,
  output logic [2:0]          upd_digit,
  output logic                seg_err,
  output logic                sel_err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [3:0]    dec_bcd;
  logic          dec_legal;

  logic [3:0]    cand_q [NDIG];
  logic [CW-1:0] cnt_q  [NDIG];
  logic [3:0]    bcd_q  [NDIG];

  logic          sel_onehot;
  logic [IW-1:0] sel_idx;
  int unsigned   sel_ones;

  logic [CW-1:0] next_cnt;
  logic          do_commit;

  seg7_pattern_to_bcd u_dec (
    .seg   (seg),
    .bcd   (dec_bcd),
    .legal (dec_legal)
  );

  // One-hot check and one-hot-to-index encode of digit_sel
  always_comb begin
    sel_ones = 0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (digit_sel[i]) begin
        sel_ones = sel_ones + 1;
        sel_idx  = IW'(i);
      end
    end
    sel_onehot = (sel_ones == 1);
  end

  // Stability count for the selected digit and its commit decision;
  // the count saturates at STABLE so it never wraps in CW bits
  always_comb begin
    if ((cnt_q[sel_idx] != '0) && (dec_bcd == cand_q[sel_idx])) begin
      next_cnt = (cnt_q[sel_idx] >= STABLE_C) ? STABLE_C : cnt_q[sel_idx] + 1'b1;
    end else begin
      next_cnt = CW'(1);
    end
    do_commit = (next_cnt == STABLE_C) &&
                (!digit_valid[sel_idx] || (bcd_q[sel_idx] != dec_bcd));
  end

  // Per-digit candidate/count/commit registers and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        cand_q[i] <= '0;
        cnt_q[i]  <= '0;
        bcd_q[i]  <= '0;
      end
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_digit   <= '0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      upd     <= 1'b0;
      seg_err <= 1'b0;
      sel_err <= 1'b0;
      if (sample_en) begin
        if (!sel_onehot) begin
          sel_err <= 1'b1;
        end else if (!dec_legal) begin
          seg_err         <= 1'b1;
          cnt_q[sel_idx]  <= '0;
        end else begin
          cand_q[sel_idx] <= dec_bcd;
          cnt_q[sel_idx]  <= next_cnt;
          if (do_commit) begin
            bcd_q[sel_idx]       <= dec_bcd;
            digit_valid[sel_idx] <= 1'b1;
            upd                  <= 1'b1;
            upd_digit            <= 3'(sel_idx);
          end
        end
      end
    end
  end

  // Flatten committed digits onto the output bus
  always_comb begin
    bcd_out = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      bcd_out[4*i +: 4] = bcd_q[i];
    end
  end

endmodule
